// File: rtl/conv_window_linebuf_3x3.sv
// conv_window_linebuf_3x3: builds 3x3 convolution windows from a raster
// pixel stream using two line buffers and a 3x3 shift-register window.
// Each accepted pixel at row>=2, col>=2 completes one window, which is
// registered and held until the downstream stage takes it.
// Handshake: a pixel moves when valid_in && in_ready; a window moves when
// valid_out && out_ready; in_ready = !valid_out || out_ready, so a held
// window stalls the input and a consumed window can be replaced in the
// same cycle.
// Optional feature: define CONV_WINDOW_STRIDE2_EN to emit windows only at
// even row/column anchors (stride 2).
module conv_window_linebuf_3x3 #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         sof_in,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         valid_out,
  output logic [287:0] window_data,
  output logic         last_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] pc;
  logic [RW-1:0] pr;
  logic          accept;
  logic          stride_ok;
  logic          emit;
  logic          is_last;

  logic [31:0]   lb1 [IMG_W];
  logic [31:0]   lb2 [IMG_W];
  logic [31:0]   win  [3][3];
  logic [31:0]   nwin [3][3];
  logic [287:0]  win_flat;

`ifdef CONV_WINDOW_STRIDE2_EN
  // Final anchor is the last even row/column of the frame.
  localparam logic [CW-1:0] COL_LAST = CW'(((IMG_W - 1) % 2 == 0) ? IMG_W - 1 : IMG_W - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(((IMG_H - 1) % 2 == 0) ? IMG_H - 1 : IMG_H - 2);
  assign stride_ok = ~pr[0] & ~pc[0];
`else
  localparam logic [CW-1:0] COL_LAST = COL_MAX;
  localparam logic [RW-1:0] ROW_LAST = ROW_MAX;
  assign stride_ok = 1'b1;
`endif

  assign in_ready = !valid_out || out_ready;
  assign accept   = valid_in && in_ready;

  // Position of the current pixel: sof_in forces (0,0) to resync the frame.
  always_comb begin
    pc      = sof_in ? '0 : col;
    pr      = sof_in ? '0 : row;
    emit    = (pr >= RW'(2)) && (pc >= CW'(2)) && stride_ok;
    is_last = (pr == ROW_LAST) && (pc == COL_LAST);
  end

  // Next window: shift columns left, new rightmost column is
  // {row r-2, row r-1, current pixel}; also flatten into tap order.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
    end
    nwin[0][2] = lb2[pc];
    nwin[1][2] = lb1[pc];
    nwin[2][2] = in_data;
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[(r*3+c)*32 +: 32] = nwin[r][c];
      end
    end
  end

  // Raster position counters, advanced per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (pc == COL_MAX) begin
        col <= '0;
        row <= (pr == ROW_MAX) ? '0 : pr + 1'b1;
      end else begin
        col <= pc + 1'b1;
        row <= pr;
      end
    end
  end

  // Line buffers and window shift register; contents need no reset because
  // rows 0 and 1 of every frame refill them before any window is emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[pc] <= lb1[pc];
      lb1[pc] <= in_data;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= nwin[r][c];
        end
      end
    end
  end

  // Output register: load a completed window, hold while stalled, drop
  // valid once consumed with nothing new behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      window_data <= '0;
    end else if (accept && emit) begin
      valid_out   <= 1'b1;
      window_data <= win_flat;
      last_out    <= is_last;
    end else if (out_ready) begin
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
    end
  end

endmodule
